mem_access_ctrl: RTL and testbench

CPU-side initiator for the byte-addressable data memory. It accepts single load/store requests (byte/half/word, signed/unsigned) and LDM/STM-style block transfers of 1-16 words from the execute stage. It drives the memory's address, data, byte-enable, write and dump pins. It returns extended load data one beat at a time and signals completion.

---
 rtl/mem_access_pkg.sv | 42 ++++
 rtl/load_extend.sv | 19 +
 rtl/mem_access_ctrl.sv | 158 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings for the CPU-side data-memory initiator: sizes, FSM states, lane enables.
package mem_access_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE,
        ST_FAULT
    } state_e;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    localparam int MAX_BEATS = 16;

    typedef logic [$clog2(MAX_BEATS)-1:0] beat_t;

    function automatic logic [3:0] size_be(input size_e sz);
        case (sz)
            SZ_BYTE: return BE_BYTE;
            SZ_HALF: return BE_HALF;
            default: return BE_WORD;
        endcase
    endfunction

    function automatic logic [31:0] lane_mask(input size_e sz);
        case (sz)
            SZ_BYTE: return 32'h0000_00FF;
            SZ_HALF: return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of the low lanes of a memory read word according to access size.
module load_extend
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  size_e       size,
    input  logic        is_signed,
    output logic [31:0] data
);

    always_comb begin
        case (size)
            SZ_BYTE: data = {{24{is_signed & rdata[7]}}, rdata[7:0]};
            SZ_HALF: data = {{16{is_signed & rdata[15]}}, rdata[15:0]};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store and block-transfer initiator: one memory beat per cycle, registered load responses,
// deferred memory-dump strobe.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter bit ALIGN_CHECK = 1'b1,
    parameter int BEAT_STRIDE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic        req_multi,
    input  logic [3:0]  req_count,
    input  logic [31:0] req_addr,
    output logic [3:0]  st_index,
    input  logic [31:0] st_data,
    output logic        rsp_valid,
    output logic [3:0]  rsp_index,
    output logic [31:0] rsp_data,
    output logic        rsp_fault,
    output logic        done,
    input  logic        dump_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  mem_byte_enable,
    output logic        mem_wr,
    output logic        mem_createdump
);

    state_e      state_q, state_d;
    beat_t       beat_q, beat_d;
    beat_t       count_q, count_d;
    logic        wr_q, wr_d;
    size_e       size_q, size_d;
    logic        signed_q, signed_d;
    logic [31:0] addr_q, addr_d;
    logic        rsp_valid_q, rsp_valid_d;
    beat_t       rsp_index_q, rsp_index_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        dump_pend_q, dump_pend_d;

    size_e       req_sz;
    logic        bad_req;
    logic [31:0] beat_addr;
    logic [31:0] ext_data;

    // Block transfers are always word-sized regardless of req_size.
    assign req_sz    = req_multi ? SZ_WORD : size_e'(req_size);
    assign bad_req   = (req_sz == SZ_RSVD) ||
                       (ALIGN_CHECK && (((req_sz == SZ_HALF) && req_addr[0]) ||
                                        ((req_sz == SZ_WORD) && (req_addr[1:0] != 2'b00))));
    assign beat_addr = addr_q + 32'(beat_q) * 32'(BEAT_STRIDE);

    load_extend u_load_extend (
        .rdata     (mem_rdata),
        .size      (size_q),
        .is_signed (signed_q),
        .data      (ext_data)
    );

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            count_q     <= '0;
            wr_q        <= 1'b0;
            size_q      <= SZ_BYTE;
            signed_q    <= 1'b0;
            addr_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_index_q <= '0;
            rsp_data_q  <= '0;
            dump_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            count_q     <= count_d;
            wr_q        <= wr_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            addr_q      <= addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_index_q <= rsp_index_d;
            rsp_data_q  <= rsp_data_d;
            dump_pend_q <= dump_pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (req_valid) state_d = bad_req ? ST_FAULT : ST_ACCESS;
            ST_ACCESS: if (beat_q == count_q) state_d = ST_DONE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        beat_d   = beat_q;
        count_d  = count_q;
        wr_d     = wr_q;
        size_d   = size_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        if (state_q == ST_IDLE) begin
            beat_d = '0;
            if (req_valid) begin
                count_d  = req_multi ? req_count : '0;
                wr_d     = req_wr;
                size_d   = req_sz;
                signed_d = req_signed;
                addr_d   = req_addr;
            end
        end else if (state_q == ST_ACCESS) begin
            beat_d = beat_q + 1'b1;
        end
        rsp_valid_d = (state_q == ST_ACCESS) && !wr_q;
        rsp_index_d = rsp_valid_d ? beat_q : rsp_index_q;
        rsp_data_d  = rsp_valid_d ? ext_data : rsp_data_q;
        // A dump request stays pending until the controller is back in IDLE.
        dump_pend_d = dump_req || (dump_pend_q && (state_q != ST_IDLE));
    end

    always_comb begin
        req_ready       = (state_q == ST_IDLE);
        done            = (state_q == ST_DONE) || (state_q == ST_FAULT);
        rsp_fault       = (state_q == ST_FAULT);
        rsp_valid       = rsp_valid_q;
        rsp_index       = rsp_index_q;
        rsp_data        = rsp_data_q;
        st_index        = '0;
        mem_addr        = '0;
        mem_wdata       = '0;
        mem_byte_enable = '0;
        mem_wr          = 1'b0;
        if (state_q == ST_ACCESS) begin
            st_index        = beat_q;
            mem_addr        = beat_addr;
            mem_byte_enable = size_be(size_q);
            mem_wr          = wr_q;
            if (wr_q) mem_wdata = st_data & lane_mask(size_q);
        end
        // Reset is synchronous, so the strobes must be blanked combinationally in the reset cycle.
        if (rst) begin
            mem_byte_enable = '0;
            mem_wr          = 1'b0;
        end
        mem_createdump = (state_q == ST_IDLE) && dump_pend_q && !rst;
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a byte-array memory model on the memory pins.
module tb_mem_access_ctrl;

    localparam int STRIDE = 4;

    typedef struct packed {
        logic [3:0]  idx;
        logic [31:0] data;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wr, req_signed, req_multi;
    logic [1:0]  req_size;
    logic [3:0]  req_count;
    logic [31:0] req_addr;
    logic [3:0]  st_index;
    logic [31:0] st_data, st_base;
    logic        rsp_valid, rsp_fault, done;
    logic [3:0]  rsp_index;
    logic [31:0] rsp_data;
    logic        dump_req;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_byte_enable;
    logic        mem_wr, mem_createdump;

    logic [7:0]  mem [0:4095];
    logic [11:0] ma0, ma1, ma2, ma3;

    rsp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_mis = 0;
    int          dump_pulses = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ALIGN_CHECK(1'b1), .BEAT_STRIDE(STRIDE)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_wr          (req_wr),
        .req_size        (req_size),
        .req_signed      (req_signed),
        .req_multi       (req_multi),
        .req_count       (req_count),
        .req_addr        (req_addr),
        .st_index        (st_index),
        .st_data         (st_data),
        .rsp_valid       (rsp_valid),
        .rsp_index       (rsp_index),
        .rsp_data        (rsp_data),
        .rsp_fault       (rsp_fault),
        .done            (done),
        .dump_req        (dump_req),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_wr          (mem_wr),
        .mem_createdump  (mem_createdump)
    );

    // Memory model: 4 KiB aliased window, combinational read, write commit at posedge.
    assign ma0 = mem_addr[11:0];
    assign ma1 = ma0 + 12'd1;
    assign ma2 = ma0 + 12'd2;
    assign ma3 = ma0 + 12'd3;
    assign mem_rdata = {mem[ma3], mem[ma2], mem[ma1], mem[ma0]};
    assign st_data   = st_base + 32'h11 * 32'(st_index);

    always @(posedge clk) begin
        if (mem_wr) begin
            if (mem_byte_enable[0]) mem[ma0] <= mem_wdata[7:0];
            if (mem_byte_enable[1]) mem[ma1] <= mem_wdata[15:8];
            if (mem_byte_enable[2]) mem[ma2] <= mem_wdata[23:16];
            if (mem_byte_enable[3]) mem[ma3] <= mem_wdata[31:24];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] preload(input int a);
        return 8'(a * 7 + 3);
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] a);
        logic [31:0] w;
        for (int l = 0; l < 4; l++) w[8*l +: 8] = mem[12'(a[11:0] + 12'(l))];
        return w;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [1:0] sz, input logic sgn);
        logic [31:0] r;
        r = w;
        if (sz == 2'b00) begin
            r = {24'h0, w[7:0]};
            if (sgn && w[7]) r[31:8] = '1;
        end else if (sz == 2'b01) begin
            r = {16'h0, w[15:0]};
            if (sgn && w[15]) r[31:16] = '1;
        end
        return r;
    endfunction

    function automatic logic [31:0] wmask(input logic [1:0] sz);
        return (sz == 2'b00) ? 32'hFF : (sz == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
    endfunction

    // Load responses are matched in order against the scoreboard.
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                check("rsp_index", 32'(rsp_index), 32'(e.idx));
                check("rsp_data", rsp_data, e.data);
            end
        end
        if (mem_createdump) dump_pulses++;
    end

    // Called at posedge+1; drives the request in cycle 0 and returns at posedge+1 of cycle 1.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic sgn, input logic multi,
                         input logic [3:0] cnt, input logic [31:0] addr);
        req_valid  = 1'b1;
        req_wr     = wr;
        req_size   = sz;
        req_signed = sgn;
        req_multi  = multi;
        req_count  = cnt;
        req_addr   = addr;
        @(negedge clk);
        check("accept_ready", 32'(req_ready), 32'd1);
        check("accept_no_be", 32'(mem_byte_enable), 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic run_xfer(input logic wr, input logic [1:0] sz, input logic sgn, input logic multi,
                            input logic [3:0] cnt, input logic [31:0] addr, input logic exp_fault,
                            input int dump_at);
        int          nb;
        logic [1:0]  esz;
        logic [3:0]  be;
        logic [31:0] a;
        nb  = multi ? int'(cnt) + 1 : 1;
        esz = multi ? 2'b10 : sz;
        be  = (esz == 2'b00) ? 4'b0001 : (esz == 2'b01) ? 4'b0011 : 4'b1111;
        if (!wr && !exp_fault) begin
            for (int i = 0; i < nb; i++) begin
                a = addr + 32'(i * STRIDE);
                exp_q.push_back('{idx: 4'(i), data: exp_load(model_word(a), esz, sgn)});
            end
        end
        issue(wr, sz, sgn, multi, cnt, addr);
        if (exp_fault) begin
            @(negedge clk);
            check("fault_pulse", 32'(rsp_fault), 32'd1);
            check("fault_done", 32'(done), 32'd1);
            check("fault_no_wr", 32'(mem_wr), 32'd0);
            check("fault_no_be", 32'(mem_byte_enable), 32'd0);
            @(posedge clk);
            #1;
            @(negedge clk);
            check("fault_clear", 32'(rsp_fault), 32'd0);
            check("fault_idle", 32'(req_ready), 32'd1);
            @(posedge clk);
            #1;
            return;
        end
        for (int i = 0; i < nb; i++) begin
            if (i == dump_at) dump_req = 1'b1;
            @(negedge clk);
            a = addr + 32'(i * STRIDE);
            check("beat_addr", mem_addr, a);
            check("beat_be", 32'(mem_byte_enable), 32'(be));
            check("beat_wr", 32'(mem_wr), 32'(wr));
            check("beat_not_done", 32'(done), 32'd0);
            check("beat_not_ready", 32'(req_ready), 32'd0);
            if (wr) begin
                check("beat_st_index", 32'(st_index), 32'(i));
                check("beat_wdata", mem_wdata, (st_base + 32'h11 * 32'(i)) & wmask(esz));
            end
            @(posedge clk);
            #1;
            dump_req = 1'b0;
        end
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd1);
        check("done_not_ready", 32'(req_ready), 32'd0);
        check("done_no_be", 32'(mem_byte_enable), 32'd0);
        if (!wr) check("done_last_rsp", 32'(rsp_valid), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = preload(i);
        rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_multi = 1'b0; req_count = 4'd0; req_addr = '0; st_base = '0; dump_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_be", 32'(mem_byte_enable), 32'd0);
        check("rst_dump", 32'(mem_createdump), 32'd0);
        @(posedge clk);
        #1;

        // Byte store with upper lanes blanked, then signed byte load back.
        st_base = 32'h1234_56A5;
        run_xfer(1'b1, 2'b00, 1'b0, 1'b0, 4'd0, 32'h100, 1'b0, -1);
        check("byte_mem", 32'(mem[12'h100]), 32'h0000_00A5);
        run_xfer(1'b0, 2'b00, 1'b1, 1'b0, 4'd0, 32'h100, 1'b0, -1);
        run_xfer(1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 32'h101, 1'b0, -1);
        run_xfer(1'b0, 2'b00, 1'b1, 1'b0, 4'd0, 32'h101, 1'b0, -1);

        // Half store, signed and unsigned half loads.
        st_base = 32'hDEAD_8001;
        run_xfer(1'b1, 2'b01, 1'b0, 1'b0, 4'd0, 32'h120, 1'b0, -1);
        check("half_mem_hi", 32'(mem[12'h121]), 32'h0000_0080);
        check("half_mem_lane2", 32'(mem[12'h122]), 32'(preload(12'h122)));
        run_xfer(1'b0, 2'b01, 1'b1, 1'b0, 4'd0, 32'h120, 1'b0, -1);
        run_xfer(1'b0, 2'b01, 1'b0, 1'b0, 4'd0, 32'h120, 1'b0, -1);

        // Faults: misaligned half, misaligned word, reserved size.
        run_xfer(1'b0, 2'b01, 1'b0, 1'b0, 4'd0, 32'h203, 1'b1, -1);
        run_xfer(1'b1, 2'b10, 1'b0, 1'b0, 4'd0, 32'h102, 1'b1, -1);
        run_xfer(1'b0, 2'b11, 1'b0, 1'b0, 4'd0, 32'h100, 1'b1, -1);

        // Block store of four beats, block load across the address wrap, word load.
        st_base = 32'h11;
        run_xfer(1'b1, 2'b00, 1'b0, 1'b1, 4'd3, 32'h400, 1'b0, -1);
        check("blk_mem_400", 32'(mem[12'h400]), 32'h11);
        check("blk_mem_40c", 32'(mem[12'h40C]), 32'h44);
        run_xfer(1'b0, 2'b00, 1'b0, 1'b1, 4'd1, 32'hFFFF_FFFC, 1'b0, -1);
        run_xfer(1'b0, 2'b10, 1'b0, 1'b0, 4'd0, 32'h404, 1'b0, -1);

        // Reset in the second beat of a four-beat store.
        st_base = 32'h11;
        issue(1'b1, 2'b10, 1'b0, 1'b1, 4'd3, 32'h500);
        @(negedge clk);
        check("rst_beat0_addr", mem_addr, 32'h500);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_cycle_no_wr", 32'(mem_wr), 32'd0);
        check("rst_cycle_no_be", 32'(mem_byte_enable), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 32'd1);
        check("post_rst_done", 32'(done), 32'd0);
        check("post_rst_addr", mem_addr, 32'd0);
        check("post_rst_wdata", mem_wdata, 32'd0);
        check("post_rst_mem500", 32'(mem[12'h500]), 32'h11);
        check("post_rst_mem504", 32'(mem[12'h504]), 32'(preload(12'h504)));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("post_rst_no_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;

        // Dump requested mid-transfer is deferred to the first IDLE cycle.
        run_xfer(1'b0, 2'b00, 1'b0, 1'b1, 4'd1, 32'h300, 1'b0, 0);
        @(negedge clk);
        check("dump_first_idle", 32'(mem_createdump), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("dump_one_cycle", 32'(mem_createdump), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("dump_total", 32'(dump_pulses), 32'd1);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
